// File: rtl/popcount_accum_if.sv
// popcount_accum_if: input beat and result handshakes of the popcount accumulator.
interface popcount_accum_if #(
    parameter int N     = 13,
    parameter int ACC_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     in_bits;
    logic             in_first;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_count;
    logic             out_sat;
    modport master (
        output in_valid, in_bits, in_first, in_last, out_ready,
        input  in_ready, out_valid, out_count, out_sat
    );
    modport slave (
        input  in_valid, in_bits, in_first, in_last, out_ready,
        output in_ready, out_valid, out_count, out_sat
    );
endinterface

// File: rtl/popcount_accum.sv
// popcount_accum: two-stage popcount with saturating per-group accumulation.
module popcount_accum #(
    parameter int N     = 13,
    parameter int ACC_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    popcount_accum_if.slave  bus
);
    localparam int CW = $clog2(N + 1);
    logic             en;
    logic             s1_valid;
    logic             s1_first;
    logic             s1_last;
    logic [CW-1:0]    s1_cnt;
    logic [CW-1:0]    pc;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] base;
    logic [ACC_W-1:0] clamped;
    logic [ACC_W:0]   sum;
    logic             sat;
    logic             sat_next;
    // A held result stalls both stages and the input together.
    assign en = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = en;
    always_comb begin
        pc = '0;
        for (int i = 0; i < N; i++) pc = pc + CW'(bus.in_bits[i]);
    end
    always_comb begin
        base     = s1_first ? '0 : acc;
        sum      = {1'b0, base} + (ACC_W + 1)'(s1_cnt);
        clamped  = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
        sat_next = sum[ACC_W] || (!s1_first && sat);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_cnt   <= '0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
        end else if (en) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_cnt   <= pc;
                s1_first <= bus.in_first;
                s1_last  <= bus.in_last;
            end
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc           <= '0;
            sat           <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_count <= '0;
            bus.out_sat   <= 1'b0;
        end else if (en) begin
            bus.out_valid <= s1_valid && s1_last;
            if (s1_valid && s1_last) begin
                bus.out_count <= clamped;
                bus.out_sat   <= sat_next;
                acc           <= '0;
                sat           <= 1'b0;
            end else if (s1_valid) begin
                acc <= clamped;
                sat <= sat_next;
            end
        end
    end
endmodule

// File: tb/tb_popcount_accum.sv
// tb_popcount_accum: directed checks of a wide (ACC_W=16) and a narrow (ACC_W=4)
// accumulator fed with identical beats.
module tb_popcount_accum;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [12:0] in_bits = '0;
    logic        in_first = 1'b0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b1;
    int          total = 0;
    int          bad = 0;

    popcount_accum_if #(.N(13), .ACC_W(16)) ifa ();
    popcount_accum_if #(.N(13), .ACC_W(4))  ifb ();

    assign ifa.in_valid  = in_valid;
    assign ifa.in_bits   = in_bits;
    assign ifa.in_first  = in_first;
    assign ifa.in_last   = in_last;
    assign ifa.out_ready = out_ready;
    assign ifb.in_valid  = in_valid;
    assign ifb.in_bits   = in_bits;
    assign ifb.in_first  = in_first;
    assign ifb.in_last   = in_last;
    assign ifb.out_ready = out_ready;

    popcount_accum #(.N(13), .ACC_W(16)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    popcount_accum #(.N(13), .ACC_W(4))  dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [12:0] b, input logic f, input logic l);
        in_valid = 1'b1;
        in_bits  = b;
        in_first = f;
        in_last  = l;
        for (int k = 0; k < 20 && !ifa.in_ready; k++) step();
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_out();
        for (int k = 0; k < 8; k++) begin
            step();
            if (ifa.out_valid) break;
        end
    endtask

    task automatic test_reset();
        #3;
        total += 4;
        if (ifa.out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", ifa.out_valid); end
        if (ifa.out_count !== 16'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", ifa.out_count); end
        if (ifa.out_sat !== 1'b0) begin bad++; $display("FAIL reset_sat got=%0b exp=0", ifa.out_sat); end
        if (ifa.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0b exp=1", ifa.in_ready); end
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single();
        in_valid = 1'b1; in_bits = 13'h1FFF; in_first = 1'b1; in_last = 1'b1;
        step();
        in_valid = 1'b0;
        total++;
        if (ifa.out_valid !== 1'b0) begin bad++; $display("FAIL single_early got=%0b exp=0", ifa.out_valid); end
        step();
        total += 3;
        if (ifa.out_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%0b exp=1", ifa.out_valid); end
        if (ifa.out_count !== 16'd13) begin bad++; $display("FAIL single_count got=%0d exp=13", ifa.out_count); end
        if (ifa.out_sat !== 1'b0) begin bad++; $display("FAIL single_sat got=%0b exp=0", ifa.out_sat); end
        step();
        total++;
        if (ifa.out_valid !== 1'b0) begin bad++; $display("FAIL single_clear got=%0b exp=0", ifa.out_valid); end
    endtask

    task automatic test_group();
        logic [12:0] bits [3] = '{13'h001F, 13'h1FFF, 13'h0000};
        int          n = 0;
        logic [15:0] got = '0;
        for (int c = 0; c < 7; c++) begin
            in_valid = c < 3;
            if (c < 3) begin
                in_bits = bits[c]; in_first = c == 0; in_last = c == 2;
            end
            step();
            if (ifa.out_valid) begin n++; got = ifa.out_count; end
        end
        total += 2;
        if (n !== 1) begin bad++; $display("FAIL group_pulses got=%0d exp=1", n); end
        if (got !== 16'd18) begin bad++; $display("FAIL group_count got=%0d exp=18", got); end
    endtask

    task automatic test_stall();
        logic [12:0] bits [3] = '{13'h001F, 13'h1FFF, 13'h0000};
        out_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            in_valid = c < 3;
            if (c < 3) begin
                in_bits = bits[c]; in_first = c == 0; in_last = c == 2;
            end
            step();
        end
        in_valid = 1'b1; in_bits = 13'h0003; in_first = 1'b1; in_last = 1'b0;
        for (int c = 0; c < 5; c++) begin
            total += 3;
            if (ifa.out_valid !== 1'b1) begin bad++; $display("FAIL stall_valid cyc=%0d got=%0b exp=1", c, ifa.out_valid); end
            if (ifa.out_count !== 16'd18) begin bad++; $display("FAIL stall_count cyc=%0d got=%0d exp=18", c, ifa.out_count); end
            if (ifa.in_ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready cyc=%0d got=%0b exp=0", c, ifa.in_ready); end
            step();
        end
        out_ready = 1'b1;
        step();
        in_bits = 13'h0007; in_first = 1'b0; in_last = 1'b1;
        step();
        in_valid = 1'b0;
        wait_out();
        total += 2;
        if (ifa.out_valid !== 1'b1) begin bad++; $display("FAIL stall_next_valid got=%0b exp=1", ifa.out_valid); end
        if (ifa.out_count !== 16'd5) begin bad++; $display("FAIL stall_next_count got=%0d exp=5", ifa.out_count); end
    endtask

    task automatic test_sat();
        send(13'h1FFF, 1'b1, 1'b0);
        send(13'h1FFF, 1'b0, 1'b1);
        wait_out();
        total += 4;
        if (ifb.out_count !== 4'd15) begin bad++; $display("FAIL sat_count got=%0d exp=15", ifb.out_count); end
        if (ifb.out_sat !== 1'b1) begin bad++; $display("FAIL sat_flag got=%0b exp=1", ifb.out_sat); end
        if (ifa.out_count !== 16'd26) begin bad++; $display("FAIL sat_wide_count got=%0d exp=26", ifa.out_count); end
        if (ifa.out_sat !== 1'b0) begin bad++; $display("FAIL sat_wide_flag got=%0b exp=0", ifa.out_sat); end
        send(13'h0007, 1'b1, 1'b1);
        wait_out();
        total += 2;
        if (ifb.out_count !== 4'd3) begin bad++; $display("FAIL sat_next_count got=%0d exp=3", ifb.out_count); end
        if (ifb.out_sat !== 1'b0) begin bad++; $display("FAIL sat_next_flag got=%0b exp=0", ifb.out_sat); end
    endtask

    task automatic test_first_discard();
        send(13'h01FF, 1'b1, 1'b0);
        send(13'h000F, 1'b1, 1'b1);
        wait_out();
        total += 2;
        if (ifa.out_count !== 16'd4) begin bad++; $display("FAIL discard_count got=%0d exp=4", ifa.out_count); end
        if (ifa.out_sat !== 1'b0) begin bad++; $display("FAIL discard_sat got=%0b exp=0", ifa.out_sat); end
        send(13'h1FFF, 1'b1, 1'b0);
        send(13'h1FFF, 1'b0, 1'b0);
        send(13'h0001, 1'b1, 1'b1);
        wait_out();
        total += 3;
        if (ifb.out_count !== 4'd1) begin bad++; $display("FAIL discard_sat_count got=%0d exp=1", ifb.out_count); end
        if (ifb.out_sat !== 1'b0) begin bad++; $display("FAIL discard_sat_flag got=%0b exp=0", ifb.out_sat); end
        if (ifa.out_count !== 16'd1) begin bad++; $display("FAIL discard_wide_count got=%0d exp=1", ifa.out_count); end
    endtask

    task automatic test_reset_mid();
        send(13'h1FFF, 1'b1, 1'b0);
        send(13'h1FFF, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        total += 4;
        if (ifa.out_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_valid got=%0b exp=0", ifa.out_valid); end
        if (ifa.out_count !== 16'd0) begin bad++; $display("FAIL rst_mid_count got=%0d exp=0", ifa.out_count); end
        if (ifa.out_sat !== 1'b0) begin bad++; $display("FAIL rst_mid_sat got=%0b exp=0", ifa.out_sat); end
        if (ifa.in_ready !== 1'b1) begin bad++; $display("FAIL rst_mid_in_ready got=%0b exp=1", ifa.in_ready); end
        step();
        rst_n = 1'b1;
        send(13'h0007, 1'b0, 1'b1);
        wait_out();
        total += 2;
        if (ifa.out_valid !== 1'b1) begin bad++; $display("FAIL rst_post_valid got=%0b exp=1", ifa.out_valid); end
        if (ifa.out_count !== 16'd3) begin bad++; $display("FAIL rst_post_count got=%0d exp=3", ifa.out_count); end
    endtask

    task automatic test_back_to_back();
        int          j = 0;
        logic [12:0] w;
        in_first = 1'b1;
        in_last  = 1'b1;
        for (int i = 0; i < 23; i++) begin
            in_valid = i < 21;
            in_bits  = 13'(i);
            step();
            if (ifa.out_valid) begin
                w = 13'(j);
                total++;
                if (ifa.out_count !== 16'($countones(w))) begin
                    bad++; $display("FAIL b2b_count idx=%0d got=%0d exp=%0d", j, ifa.out_count, $countones(w));
                end
                j++;
            end
        end
        total++;
        if (j !== 21) begin bad++; $display("FAIL b2b_results got=%0d exp=21", j); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_group();
        test_stall();
        test_sat();
        test_first_discard();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/popcount_accum.md
# popcount_accum

Parametrised, pipelined population-count accumulator for the NPU's binary/XNOR datapath. Each beat counts the set bits of an N-bit input word. Counts are summed across a multi-beat group, framed by first/last flags, into a saturating ACC_W-bit result. It has valid/ready handshakes on both sides, so it sits between the XNOR array and the activation/threshold stage.

## Interface
- N, default 13: input word width in bits; N ≥ 1.
- ACC_W, default 16: accumulator and result width; ACC_W ≥ CW, where CW = $clog2(N+1).
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input beat present.
- in_ready  out  1  block can accept a beat.
- in_bits  in  N  word to be counted.
- in_first  in  1  beat opens a new group; the accumulator restarts from 0.
- in_last  in  1  beat closes the group; a result is produced.
- out_valid  out  1  result held on out_count/out_sat.
- out_ready  in  1  downstream accepts the result.
- out_count  out  ACC_W  group sum, saturated.
- out_sat  out  1  saturation occurred at some point in this group.

## Operation
- Global advance enable: en = !out_valid || out_ready. in_ready = en (combinational). A beat is accepted when in_valid && in_ready.
- Stage 1, on each en edge:
  - s1_valid <= accepted.
  - On accept: s1_cnt <= popcount(in_bits), CW bits, exact, never overflows; s1_first <= in_first; s1_last <= in_last.
- Stage 2, on each en edge with s1_valid:
  - base = s1_first ? 0 : acc.
  - sum = base + s1_cnt, computed at ACC_W+1 bits.
  - If sum > 2^ACC_W−1: clamp to 2^ACC_W−1 and set sat_next = 1. Otherwise sat_next = (s1_first ? 0 : sat) for the sticky flag.
  - If s1_last: out_count <= clamped sum, out_sat <= sat_next, out_valid <= 1, acc <= 0, sat <= 0.
  - Else: acc <= clamped sum, sat <= sat_next.
- Output: out_valid clears on an en edge where no last beat is completing. With out_valid && out_ready and a new last beat completing in the same cycle, the new result replaces the old one with no bubble.
- No group open: the accumulator is 0, so a beat without in_first starts from 0. in_first on a beat while a group is open discards the open partial sum and its sat flag.
- in_first && in_last on the same beat: single-beat group, result = popcount.
- in_bits, in_first and in_last are ignored when the beat is not accepted.

## Timing
- Reset values (asynchronous, while rst_n = 0): s1_valid = 0, s1_cnt = 0, acc = 0, sat = 0, out_valid = 0, out_count = 0, out_sat = 0. in_ready reads 1 during and after reset.
- Latency: a last beat accepted at edge k gives out_valid = 1 after edge k+1. Throughput is 1 beat per cycle while out_ready = 1.
- Backpressure with out_valid && !out_ready:
  - en = 0, in_ready = 0.
  - Stage 1, acc, sat, out_count and out_sat hold.
  - No beat is lost or duplicated.
- Reset mid-group: the group is abandoned entirely. The first post-reset result counts only post-reset beats.
- Stage 1 holding a non-last beat while the output stalls: that beat is also held. It is folded into acc only on the next en edge.

## Test plan
- N=13, ACC_W=16. One beat in_bits=13'h1FFF, first=last=1 -> out_valid after 2 edges, out_count=13, out_sat=0.
- Three beats, first on beat 0, last on beat 2, with counts 5, 13, 0 (e.g. 13'h001F, 13'h1FFF, 0), back-to-back -> single result out_count=18. out_valid asserts exactly once.
- Same three-beat group with out_ready=0 for 5 cycles at result time, then a second group queued:
  - in_ready=0 while stalled; out_count holds 18.
  - After release the next group's result appears with correct value and no lost beat.
- ACC_W=4, N=13. Beats of 13 and 13 (first, last) -> out_count=15, out_sat=1. Next single-beat group of 3 -> out_count=3, out_sat=0.
- Open group with partial sum 9, then a beat with in_first=1, count 4 and last -> out_count=4. Separately, rst_n pulsed low mid-group -> all outputs 0 immediately, and the next group sums only post-reset beats.
- Consecutive single-beat groups every cycle with out_ready=1, in_bits incrementing 0..20 -> results equal popcount of each word, in order, one per cycle after 2-cycle fill.
